vout_timing_gen: RTL and testbench
==================================

// Module: vout_timing_gen
// PURPOSE
//  Video transmitter: generates the raster timing (hs/vs/de) and a 24-bit RGB test pattern
//  for one video port. Drives the vin side of the fantasy datapath on the bench and the
//  board self-test path (loopback via vin_*), so patterns are block-aligned to KH x KV.
//  Single clock domain; pixel clock only.
// PARAMETERS
//  H_WIDTH  1920  active pixels per line
//  H_START  2008  first hcount of hsync pulse
//  H_SYNC   44    hsync pulse width, pixels
//  H_TOTAL  2200  pixels per line incl. blanking
//  V_HEIGHT 1080  active lines per frame
//  V_START  1084  first line of vsync pulse
//  V_SYNC   5     vsync pulse width, lines
//  V_TOTAL  1125  lines per frame
//  HS_POL   1     hsync active level; VS_POL 1 vsync active level
//  KH       30    pattern block width; KV 30 pattern block height
// PORTS
//  clk_i        in   1   pixel clock
//  rst_i        in   1   synchronous reset, active-high
//  en_i         in   1   run enable, sampled at frame start only
//  pat_sel_i    in   2   pattern select, sampled at frame start only
//  color_i      in   24  solid colour for pat 2, sampled at frame start only
//  hs_o         out  1   hsync (HS_POL)
//  vs_o         out  1   vsync (VS_POL)
//  de_o         out  1   data enable, high in active area
//  data_o       out  24  {R,G,B}; 0 when de_o low
//  frame_o      out  1   1-cycle pulse with first active pixel of frame
// BEHAVIOUR
//  - Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h wraps to 0 and v increments; v wraps at
//    V_TOTAL-1 with h==H_TOTAL-1. All outputs registered: 1-cycle latency from (h,v).
//  - de_o = (h<H_WIDTH)&&(v<V_HEIGHT); hs_o active iff H_START<=h<H_START+H_SYNC;
//    vs_o active iff V_START<=v<V_START+V_SYNC (edges coincide with h==0).
//  - Reset: h=v=0, idle; hs_o=~HS_POL, vs_o=~VS_POL, de_o=0, data_o=0, frame_o=0.
//  - Idle/run: at (h,v)==(0,0) en_i is sampled. en_i=0 -> counters hold at (0,0), outputs
//    stay at reset levels. en_i=1 -> frame runs to completion; en_i deassertion mid-frame
//    has no effect until next (0,0). pat_sel_i/color_i latched at the same instant
//    (no tearing).
//  - Block cursor: bx/kx and by/ky sub-counters (no divider); kx counts 0..KH-1 within
//    active line, bx increments on kx wrap, reset at h==0; ky/by likewise per active line,
//    reset at v==0. Partial last block (H_WIDTH%KH!=0) allowed.
//  - Patterns (active pixels only):
//    0: checker, (bx^by)[0] ? 24'hFFFFFF : 24'h000000
//    1: horizontal ramp, {3{h[7:0]}} (wraps every 256 px)
//    2: solid latched color_i
//    3: block gray, g=((bx+by)<<3)[7:0], data={g,g,g}
//  - frame_o asserted with de_o on pixel (0,0) of every running frame.
//  - Widths: counters $clog2(H_TOTAL)/$clog2(V_TOTAL); bx,by sized for ceil(W/K).
//  - Reset mid-frame: next cycle returns to reset state; restart needs en_i at (0,0).
// STRUCTURE
//  - Shared package video_timing_pkg: 1080p60 timing localparams (H_*/V_* defaults),
//    RGB black/white constants, pattern-select encodings.
//  - One sub-module: blk_axis_counter (position + block index/offset for one axis),
//    instantiated for h and v.
// TESTING (small params: H_WIDTH=8 H_START=10 H_SYNC=2 H_TOTAL=12 V_HEIGHT=4 V_START=5
//          V_SYNC=1 V_TOTAL=6 KH=KV=2, POL=1)
//  - Reset held 3 cycles, en_i=0 for 50 cycles -> hs/vs/de/data/frame all 0.
//  - en_i=1 -> frame_o at 1 cycle after (0,0); 8 de cycles per line, 12-cycle period,
//    hs high at line cycles 10-11, vs high for line 5 only, 72 cycles/frame.
//  - pat 0 -> line 0 data FFFFFF? no: 000000,000000,FFFFFF,FFFFFF,...; line 2 inverted.
//  - pat 3 -> pixel (h=6,v=2): g=(3+1)<<3=0x20, data=202020.
//  - Change pat_sel_i/en_i=0 mid-frame -> current frame unchanged; new pattern / idle
//    from next (0,0).
//  - rst_i pulse at h=5,v=2 -> outputs at reset levels next cycle; clean frame restarts.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing package: 1080p60 defaults, RGB constants and pattern encodings.
package video_timing_pkg;

    localparam int H_WIDTH_DEF  = 1920;
    localparam int H_START_DEF  = 2008;
    localparam int H_SYNC_DEF   = 44;
    localparam int H_TOTAL_DEF  = 2200;
    localparam int V_HEIGHT_DEF = 1080;
    localparam int V_START_DEF  = 1084;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_TOTAL_DEF  = 1125;
    localparam int KH_DEF       = 30;
    localparam int KV_DEF       = 30;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

    typedef enum logic [1:0] {
        PAT_CHECKER = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_GRAY    = 2'd3
    } pat_sel_e;

    // Bit width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blk_axis_counter.sv
// One raster axis: position counter plus block index within the active region.
module blk_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL  = H_TOTAL_DEF,
    parameter int ACTIVE = H_WIDTH_DEF,
    parameter int K      = KH_DEF,
    parameter int PW     = clog2_min1(TOTAL),
    parameter int BW     = clog2_min1((ACTIVE + K - 1) / K)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          step_i,
    output logic [PW-1:0] pos_o,
    output logic [BW-1:0] blk_o,
    output logic          wrap_o
);

    localparam int KW = clog2_min1(K);
    localparam logic [PW-1:0] LAST     = PW'(TOTAL - 1);
    localparam logic [PW-1:0] ACT_LAST = PW'(ACTIVE - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);

    logic [PW-1:0] r_pos;
    logic [BW-1:0] r_blk;
    logic [KW-1:0] r_off;

    // Position, block index and in-block offset; the block cursor freezes past the active area.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pos <= '0;
            r_blk <= '0;
            r_off <= '0;
        end else if (step_i) begin
            if (r_pos == LAST) begin
                r_pos <= '0;
                r_blk <= '0;
                r_off <= '0;
            end else begin
                r_pos <= r_pos + PW'(1);
                if (r_pos < ACT_LAST) begin
                    if (r_off == K_LAST) begin
                        r_off <= '0;
                        r_blk <= r_blk + BW'(1);
                    end else begin
                        r_off <= r_off + KW'(1);
                    end
                end
            end
        end
    end

    assign pos_o  = r_pos;
    assign blk_o  = r_blk;
    assign wrap_o = (r_pos == LAST);

endmodule

// File: rtl/vout_timing_gen.sv
// Video transmitter: raster timing (hs/vs/de) and block-aligned RGB test patterns.
module vout_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_WIDTH  = H_WIDTH_DEF,
    parameter int H_START  = H_START_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_HEIGHT = V_HEIGHT_DEF,
    parameter int V_START  = V_START_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int KH       = KH_DEF,
    parameter int KV       = KV_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  pat_sel_i,
    input  logic [23:0] color_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic        frame_o
);

    localparam int HPW = clog2_min1(H_TOTAL);
    localparam int VPW = clog2_min1(V_TOTAL);
    localparam int HBW = clog2_min1((H_WIDTH + KH - 1) / KH);
    localparam int VBW = clog2_min1((V_HEIGHT + KV - 1) / KV);

    localparam logic [HPW:0] H_ACT  = (HPW+1)'(H_WIDTH);
    localparam logic [HPW:0] HS_BEG = (HPW+1)'(H_START);
    localparam logic [HPW:0] HS_END = (HPW+1)'(H_START + H_SYNC);
    localparam logic [VPW:0] V_ACT  = (VPW+1)'(V_HEIGHT);
    localparam logic [VPW:0] VS_BEG = (VPW+1)'(V_START);
    localparam logic [VPW:0] VS_END = (VPW+1)'(V_START + V_SYNC);

    logic [HPW-1:0] w_h;
    logic [VPW-1:0] w_v;
    logic [HBW-1:0] w_bx;
    logic [VBW-1:0] w_by;
    logic           w_hwrap;
    logic           w_vwrap;
    logic           w_origin;
    logic           w_run;
    pat_sel_e       w_pat;
    logic [23:0]    w_color;
    logic [7:0]     w_sum;
    logic [7:0]     w_gray;
    logic [7:0]     w_ramp;

    logic           w_hs_n;
    logic           w_vs_n;
    logic           w_de_n;
    logic [23:0]    w_data_n;
    logic           w_frame_n;

    pat_sel_e       r_pat;
    logic [23:0]    r_color;
    logic           r_hs;
    logic           r_vs;
    logic           r_de;
    logic [23:0]    r_data;
    logic           r_frame;

    // Anywhere other than (0,0) a frame is in flight; at (0,0) en_i decides.
    assign w_origin = (w_h == '0) && (w_v == '0);
    assign w_run    = !w_origin || en_i;

    blk_axis_counter #(
        .TOTAL (H_TOTAL), .ACTIVE (H_WIDTH), .K (KH), .PW (HPW), .BW (HBW)
    ) u_h_axis (
        .clk_i (clk_i), .rst_i (rst_i), .step_i (w_run),
        .pos_o (w_h), .blk_o (w_bx), .wrap_o (w_hwrap)
    );

    blk_axis_counter #(
        .TOTAL (V_TOTAL), .ACTIVE (V_HEIGHT), .K (KV), .PW (VPW), .BW (VBW)
    ) u_v_axis (
        .clk_i (clk_i), .rst_i (rst_i), .step_i (w_run && w_hwrap),
        .pos_o (w_v), .blk_o (w_by), .wrap_o (w_vwrap)
    );

    // The first pixel of a frame uses the inputs directly; the rest use the latched copy.
    assign w_pat   = w_origin ? pat_sel_e'(pat_sel_i) : r_pat;
    assign w_color = w_origin ? color_i : r_color;
    assign w_sum   = 8'(w_bx) + 8'(w_by);
    assign w_gray  = {w_sum[4:0], 3'b000};
    assign w_ramp  = 8'(w_h);

    // Next-state values of every output for the current raster position.
    always_comb begin
        w_hs_n    = ~HS_POL;
        w_vs_n    = ~VS_POL;
        w_de_n    = 1'b0;
        w_data_n  = RGB_BLACK;
        w_frame_n = 1'b0;
        if (w_run) begin
            w_de_n    = ({1'b0, w_h} < H_ACT) && ({1'b0, w_v} < V_ACT);
            w_hs_n    = (({1'b0, w_h} >= HS_BEG) && ({1'b0, w_h} < HS_END)) ? HS_POL : ~HS_POL;
            w_vs_n    = (({1'b0, w_v} >= VS_BEG) && ({1'b0, w_v} < VS_END)) ? VS_POL : ~VS_POL;
            w_frame_n = w_origin;
            if (w_de_n) begin
                case (w_pat)
                    PAT_CHECKER: w_data_n = (w_bx[0] ^ w_by[0]) ? RGB_WHITE : RGB_BLACK;
                    PAT_RAMP:    w_data_n = {3{w_ramp}};
                    PAT_SOLID:   w_data_n = w_color;
                    PAT_GRAY:    w_data_n = {3{w_gray}};
                    default:     w_data_n = RGB_BLACK;
                endcase
            end else begin
                w_data_n = RGB_BLACK;
            end
        end else begin
            w_frame_n = 1'b0;
        end
    end

    // Pattern selection and colour latched once per frame so a frame never tears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pat   <= PAT_CHECKER;
            r_color <= RGB_BLACK;
        end else if (w_origin && en_i) begin
            r_pat   <= pat_sel_e'(pat_sel_i);
            r_color <= color_i;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_de    <= 1'b0;
            r_data  <= RGB_BLACK;
            r_frame <= 1'b0;
        end else begin
            r_hs    <= w_hs_n;
            r_vs    <= w_vs_n;
            r_de    <= w_de_n;
            r_data  <= w_data_n;
            r_frame <= w_frame_n;
        end
    end

    assign hs_o    = r_hs;
    assign vs_o    = r_vs;
    assign de_o    = r_de;
    assign data_o  = r_data;
    assign frame_o = r_frame;

    logic w_unused;
    assign w_unused = w_vwrap;

endmodule

// File: tb/tb_vout_timing_gen.sv
// Bench for vout_timing_gen at a tiny raster, checked against a frame-position reference model.
module tb_vout_timing_gen;

    localparam int HW  = 8;
    localparam int HST = 10;
    localparam int HSY = 2;
    localparam int HT  = 12;
    localparam int VH  = 4;
    localparam int VST = 5;
    localparam int VSY = 1;
    localparam int VT  = 6;
    localparam int K   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pat;
    logic [23:0] color;
    logic        hs, vs, de, frame;
    logic [23:0] data;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_pos = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [23:0] m_color = 24'h000000;
    logic        e_hs, e_vs, e_de, e_fr;
    logic [23:0] e_data;

    vout_timing_gen #(
        .H_WIDTH (HW), .H_START (HST), .H_SYNC (HSY), .H_TOTAL (HT),
        .V_HEIGHT (VH), .V_START (VST), .V_SYNC (VSY), .V_TOTAL (VT),
        .HS_POL (1'b1), .VS_POL (1'b1), .KH (K), .KV (K)
    ) dut (
        .clk_i (clk), .rst_i (rst), .en_i (en), .pat_sel_i (pat), .color_i (color),
        .hs_o (hs), .vs_o (vs), .de_o (de), .data_o (data), .frame_o (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the frame position, clock the DUT, compare.
    task automatic cyc();
        int h, v, bx, by;
        logic [7:0] g;
        e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fr = 1'b0; e_data = 24'h000000;
        if (rst) begin
            m_pos = 0;
        end else if (m_pos == 0 && !en) begin
            m_pos = 0;
        end else begin
            if (m_pos == 0) begin
                m_pat   = pat;
                m_color = color;
            end
            h    = m_pos % HT;
            v    = m_pos / HT;
            e_de = (h < HW) && (v < VH);
            e_hs = (h >= HST) && (h < HST + HSY);
            e_vs = (v >= VST) && (v < VST + VSY);
            e_fr = (m_pos == 0);
            bx   = h / K;
            by   = v / K;
            if (e_de) begin
                case (m_pat)
                    2'd0: e_data = ((bx + by) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                    2'd1: begin g = 8'(h % 256); e_data = {g, g, g}; end
                    2'd2: e_data = m_color;
                    default: begin g = 8'(((bx + by) * 8) % 256); e_data = {g, g, g}; end
                endcase
            end
            m_pos = (m_pos + 1) % (HT * VT);
        end
        @(posedge clk);
        #1;
        chk("hs", {23'd0, hs}, {23'd0, e_hs});
        chk("vs", {23'd0, vs}, {23'd0, e_vs});
        chk("de", {23'd0, de}, {23'd0, e_de});
        chk("frame", {23'd0, frame}, {23'd0, e_fr});
        chk("data", data, e_data);
    endtask

    task automatic run_to(input int p);
        int k = 0;
        while (m_pos != p && k < 500) begin
            cyc();
            k++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pat = 2'd0; color = 24'h000000;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (50) cyc();
        chk("idle_de", {23'd0, de}, 24'd0);
        chk("idle_data", data, 24'h000000);

        // Checker frame: first pixel carries frame_o, block 1 of line 0 is white, line 2 inverted.
        en = 1'b1; pat = 2'd0;
        cyc();
        chk("first_frame", {23'd0, frame}, 24'd1);
        chk("first_data", data, 24'h000000);
        cyc();
        cyc();
        chk("chk_l0_px2", data, 24'hFFFFFF);
        run_to(24);
        cyc();
        chk("chk_l2_px0", data, 24'hFFFFFF);
        run_to(0);

        // Block gray frame, then mid-frame pattern change and disable.
        pat = 2'd3;
        run_to(30);
        cyc();
        chk("gray_px6_2", data, 24'h202020);
        pat = 2'd1; en = 1'b0;
        run_to(0);
        repeat (10) cyc();
        chk("idle_frame", {23'd0, frame}, 24'd0);

        // Solid frame, reset pulse at (5,2), clean restart.
        en = 1'b1; pat = 2'd2; color = 24'($urandom);
        run_to(29);
        rst = 1'b1;
        cyc();
        chk("rst_de", {23'd0, de}, 24'd0);
        rst = 1'b0;
        cyc();
        chk("restart_frame", {23'd0, frame}, 24'd1);
        run_to(0);

        // Randomised run.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) en = ~en;
            pat   = 2'($urandom_range(0, 3));
            color = 24'($urandom);
            rst   = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
